// File: rtl/distfilter_if.sv
// distfilter_if: ring buffer read port plus filtered-distance outputs.
// master = distfilter (drives the read address and the published result),
// slave  = ring buffer / sensor / downstream side.
interface distfilter_if #(
    parameter int W  = 12,
    parameter int AW = 3
);
    logic          wrstrobe;
    logic [AW-1:0] rdaddr;
    logic [W-1:0]  rddata;
    logic [W-1:0]  filtered;
    logic          valid;
    logic          busy;
    logic          primed;

    modport master (
        input  wrstrobe,
        input  rddata,
        output rdaddr,
        output filtered,
        output valid,
        output busy,
        output primed
    );

    modport slave (
        output wrstrobe,
        output rddata,
        input  rdaddr,
        input  filtered,
        input  valid,
        input  busy,
        input  primed
    );
endinterface

// File: rtl/distfilter.sv
// distfilter: after each ring buffer write strobe, sweeps all DEPTH entries
// through the buffer's registered read port, accumulates them and publishes a
// filtered distance with a one-cycle valid pulse.
//
// Optional feature: define DISTFILTER_OUTLIER_EN to drop the minimum and
// maximum sample of each sweep and publish floor((sum-min-max)*171/1024),
// saturated to the W-bit range. This adds a SCALE state (one extra cycle).
module distfilter #(
    parameter int DEPTH = 8,
    parameter int W     = 12
) (
    input  logic         clk,
    input  logic         reset,
    distfilter_if.master bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = W + AW;          // accumulator width, cannot overflow
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LAST,
`ifdef DISTFILTER_OUTLIER_EN
        SCALE,
`endif
        DONE
    } state_t;

    state_t        state;
    logic [SW-1:0] acc;
    logic [3:0]    strobe_cnt;
    logic          pending;
    logic [AW-1:0] rdaddr;
    logic [W-1:0]  filtered;
    logic          valid;
    logic          busy;
    logic          primed;
    logic [SW-1:0] acc_next;

    assign primed   = (strobe_cnt >= 4'(DEPTH));
    assign acc_next = acc + SW'(bus.rddata);

`ifdef DISTFILTER_OUTLIER_EN
    logic [W-1:0]    min_s;
    logic [W-1:0]    max_s;
    logic [W-1:0]    min_next;
    logic [W-1:0]    max_next;
    logic [SW-1:0]   trimmed;
    logic [SW+7:0]   product;
    logic [SW-3:0]   scaled;
    logic [W-1:0]    scaled_sat;

    // Running min/max including the sample arriving this cycle; strict compares
    // keep a single instance of tied extremes.
    always_comb begin
        min_next = (bus.rddata < min_s) ? bus.rddata : min_s;
        max_next = (bus.rddata > max_s) ? bus.rddata : max_s;
    end

    // Drop the extremes, multiply by 171/1024 (~1/6) and clamp to W bits.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path so no latch is inferred.
        trimmed    = acc - SW'(min_s) - SW'(max_s);
        product    = (SW+8)'(trimmed) * (SW+8)'(171);
        scaled     = product[SW+7:10];
        scaled_sat = scaled[SW-3] ? {W{1'b1}} : scaled[W-1:0];
    end
`endif

    // Sweep sequencer: read address, accumulation, pending strobe, strobe count, outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            acc        <= '0;
            strobe_cnt <= '0;
            pending    <= 1'b0;
            rdaddr     <= '0;
            filtered   <= '0;
            valid      <= 1'b0;
            busy       <= 1'b0;
`ifdef DISTFILTER_OUTLIER_EN
            min_s      <= {W{1'b1}};
            max_s      <= '0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            valid <= 1'b0;

            if (bus.wrstrobe && strobe_cnt != 4'hF)
                strobe_cnt <= strobe_cnt + 4'd1;

            // Strobes arriving mid-sweep (including DONE) merge into one pending sweep.
            if (bus.wrstrobe && state != IDLE)
                pending <= 1'b1;

            case (state)
                IDLE: begin
                    if (bus.wrstrobe) begin
                        state  <= READ;
                        rdaddr <= '0;
                        acc    <= '0;
                        busy   <= 1'b1;
`ifdef DISTFILTER_OUTLIER_EN
                        min_s  <= {W{1'b1}};
                        max_s  <= '0;
`endif
                    end
                end

                READ: begin
                    // Read data lags the address by one cycle; nothing to add on address 0.
                    if (rdaddr != '0) begin
                        acc   <= acc_next;
`ifdef DISTFILTER_OUTLIER_EN
                        min_s <= min_next;
                        max_s <= max_next;
`endif
                    end
                    if (rdaddr == LAST_ADDR) begin
                        state  <= LAST;
                        rdaddr <= '0;
                    end else begin
                        rdaddr <= rdaddr + 1'b1;
                    end
                end

                LAST: begin
                    acc <= acc_next;
`ifdef DISTFILTER_OUTLIER_EN
                    min_s <= min_next;
                    max_s <= max_next;
                    state <= SCALE;
`else
                    if (primed) begin
                        filtered <= acc_next[SW-1:AW];
                        valid    <= 1'b1;
                    end
                    state <= DONE;
`endif
                end

`ifdef DISTFILTER_OUTLIER_EN
                SCALE: begin
                    if (primed) begin
                        filtered <= scaled_sat;
                        valid    <= 1'b1;
                    end
                    state <= DONE;
                end
`endif

                DONE: begin
                    if (pending || bus.wrstrobe) begin
                        state   <= READ;
                        pending <= 1'b0;
                        rdaddr  <= '0;
                        acc     <= '0;
`ifdef DISTFILTER_OUTLIER_EN
                        min_s   <= {W{1'b1}};
                        max_s   <= '0;
`endif
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rdaddr   = rdaddr;
    assign bus.filtered = filtered;
    assign bus.valid    = valid;
    assign bus.busy     = busy;
    assign bus.primed   = primed;

endmodule

// File: tb/tb_distfilter.sv
// tb_distfilter: directed test of distfilter against a behavioural ring buffer
// with a registered read port. Expected values are computed by hand.
`timescale 1ns/1ps
module tb_distfilter;

`ifdef DISTFILTER_OUTLIER_EN
    localparam int LAT = 11;
`else
    localparam int LAT = 10;
`endif

    logic clk;
    logic reset;
    logic [11:0] mem [8];
    int tests;
    int fails;

    distfilter_if #(.W(12), .AW(3)) bus ();

    distfilter #(.DEPTH(8), .W(12)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Ring buffer model: registered read, data valid the cycle after the address.
    always @(posedge clk) bus.rddata <= mem[bus.rdaddr];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish before 2 ms");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill(input int v);
        for (int i = 0; i < 8; i++) mem[i] = 12'(v);
    endtask

    task automatic ramp();
        for (int i = 0; i < 8; i++) mem[i] = 12'(10 * (i + 1));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            check("idle_valid", bus.valid, 0);
            tick();
        end
    endtask

    // One strobe in cycle T, then a cycle-by-cycle check of T+1..T+LAT and T+LAT+1.
    task automatic sweep(input string name, input bit exp_valid, input int exp_filt);
        bus.wrstrobe = 1'b1;
        tick();
        bus.wrstrobe = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            check($sformatf("%s_busy_T%0d", name, k), bus.busy, 1);
            check($sformatf("%s_valid_T%0d", name, k), bus.valid, (k == LAT) && exp_valid);
            if (k <= 8)
                check($sformatf("%s_rdaddr_T%0d", name, k), bus.rdaddr, k - 1);
            if (k == LAT)
                check($sformatf("%s_filtered", name), bus.filtered, exp_filt);
            tick();
        end
        check($sformatf("%s_busy_end", name), bus.busy, 0);
        check($sformatf("%s_valid_end", name), bus.valid, 0);
        check($sformatf("%s_rdaddr_end", name), bus.rdaddr, 0);
    endtask

    task automatic check_reset_outputs(input string name);
        check($sformatf("%s_rdaddr", name), bus.rdaddr, 0);
        check($sformatf("%s_filtered", name), bus.filtered, 0);
        check($sformatf("%s_valid", name), bus.valid, 0);
        check($sformatf("%s_busy", name), bus.busy, 0);
        check($sformatf("%s_primed", name), bus.primed, 0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        bus.wrstrobe = 1'b0;
        fill(0);
        tick();
        tick();
        check_reset_outputs("rst");
        reset = 1'b0;
        tick();

        // Priming: 7 strobes give no valid and leave filtered at 0.
        fill(100);
        for (int s = 0; s < 7; s++) begin
            sweep($sformatf("prime%0d", s), 1'b0, 0);
            check($sformatf("prime%0d_primed", s), bus.primed, 0);
            idle(8);
        end
        check("prime_filtered_held", bus.filtered, 0);
        // 8th strobe: primed and valid with mean 100.
        sweep("prime7", 1'b1, 100);
        check("prime7_primed", bus.primed, 1);
        idle(8);

        // Ramp 10..80: mean 45; trimmed (360-10-80)*171>>10 = 45.
        ramp();
        sweep("ramp", 1'b1, 45);
        check("ramp_held", bus.filtered, 45);
        idle(8);

        // Full scale: 4095 in both builds (trimmed build saturates raw 4102).
        fill(4095);
        sweep("full", 1'b1, 4095);
        idle(8);

        // Back-to-back: strobes at T, T+4, T+6 give exactly two valids.
        ramp();
        bus.wrstrobe = 1'b1;
        tick();
        bus.wrstrobe = 1'b0;
        for (int k = 1; k <= 2 * LAT; k++) begin
            bus.wrstrobe = (k == 4) || (k == 6);
            check($sformatf("b2b_busy_T%0d", k), bus.busy, 1);
            check($sformatf("b2b_valid_T%0d", k), bus.valid, (k == LAT) || (k == 2 * LAT));
            if (k == LAT || k == 2 * LAT)
                check($sformatf("b2b_filtered_T%0d", k), bus.filtered, 45);
            tick();
        end
        bus.wrstrobe = 1'b0;
        check("b2b_busy_end", bus.busy, 0);
        check("b2b_valid_end", bus.valid, 0);
        idle(8);

        // Reset mid-sweep at T+5: aborts, no valid, everything back to reset values.
        fill(100);
        bus.wrstrobe = 1'b1;
        tick();
        bus.wrstrobe = 1'b0;
        for (int k = 1; k < 5; k++) begin
            check($sformatf("abort_valid_T%0d", k), bus.valid, 0);
            tick();
        end
        reset = 1'b1;
        #2;
        check_reset_outputs("abort");
        tick();
        check("abort_hold_valid", bus.valid, 0);
        tick();
        reset = 1'b0;
        idle(4);
        check_reset_outputs("abort_release");

        // After release, priming restarts: 7 sweeps without valid, 8th publishes.
        for (int s = 0; s < 7; s++) begin
            sweep($sformatf("reprime%0d", s), 1'b0, 0);
            check($sformatf("reprime%0d_primed", s), bus.primed, 0);
            idle(8);
        end
        sweep("reprime7", 1'b1, 100);
        check("reprime7_primed", bus.primed, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
